// File: rtl/tick_updown_counter.sv
// Purpose : free-running prescaler tick plus a WIDTH-bit up/down counter with
//           programmable modulus (MAX_VAL+1), wrap/saturate modes, sync load
//           and a one-cycle terminal-count pulse for cascading.
// Ports   : clk, rst (sync, active-low); en, up_dn, sat, load, load_val in;
//           q (count), tc (terminal count), tick (prescaler tick) out, all
//           registered.
// Latency : tick is high in the cycle after the prescaler wraps; the count step
//           lands on the following edge. Load takes effect on the next edge.
module tick_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter int              DIV     = 100_000_000,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             tick
);

  // DIV=1 would need a zero-width prescaler; keep one bit that never moves.
  localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX_Q    = MAX_VAL[WIDTH-1:0];

  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_tc;
  logic             w_at_max;
  logic             w_at_zero;

  // Prescaler: independent of every control input except reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PW'(1);
      r_tick  <= 1'b0;
    end
  end

  assign w_at_max  = (r_q == MAX_Q);
  assign w_at_zero = (r_q == '0);

  // Loads above the modulus are clamped so q never leaves 0..MAX_VAL.
  assign w_load_q = (load_val > MAX_Q) ? MAX_Q : load_val;

  // Step result for the current direction; boundary steps raise tc whether
  // they wrap or saturate, so a saturated counter still reports each tick.
  always_comb begin
    w_step_q  = r_q;
    w_step_tc = 1'b0;
    if (up_dn) begin
      if (w_at_max) begin
        w_step_tc = 1'b1;
        w_step_q  = sat ? MAX_Q : '0;
      end else begin
        w_step_q  = r_q + WIDTH'(1);
      end
    end else begin
      if (w_at_zero) begin
        w_step_tc = 1'b1;
        w_step_q  = sat ? '0 : MAX_Q;
      end else begin
        w_step_q  = r_q - WIDTH'(1);
      end
    end
  end

  // Priority: reset > load > (tick & en) step > hold. The registered tick is
  // used, so the step lands one edge after tick is visible on the port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (load) begin
      r_q  <= w_load_q;
      r_tc <= 1'b0;
    end else if (r_tick && en) begin
      r_q  <= w_step_q;
      r_tc <= w_step_tc;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign tick = r_tick;

endmodule

// File: tb/tb_tick_updown_counter.sv
module tb_tick_updown_counter;

  localparam int W    = 4;
  localparam int DIVV = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, sat, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc, tick;

  // Second instance: DIV=1, default modulus 16, counting up freely.
  logic         en1 = 1'b1, up1 = 1'b1, sat1 = 1'b0, load1 = 1'b0;
  logic [W-1:0] lv1 = '0;
  logic [W-1:0] q1;
  logic         tc1, tick1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_updown_counter #(.WIDTH(W), .DIV(DIVV), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .tick(tick)
  );

  tick_updown_counter #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .up_dn(up1), .sat(sat1), .load(load1),
    .load_val(lv1), .q(q1), .tc(tc1), .tick(tick1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: n = edges since reset release; tick every DIV-th edge;
  // count arithmetic done on plain integers modulo MAXV+1.
  int  n = 0;
  int  m_q = 0;
  bit  m_tc = 0, m_tick = 0, started = 0;
  always @(posedge clk) begin
    bit prev_tick;
    started = 1;
    if (!rst) begin
      n = 0; m_q = 0; m_tc = 0; m_tick = 0;
    end else begin
      prev_tick = m_tick;
      n++;
      m_tick = (n % DIVV) == 0;
      m_tc = 0;
      if (load) begin
        m_q = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      end else if (prev_tick && en) begin
        if (up_dn) begin
          if (m_q == MAXV) begin m_tc = 1; if (!sat) m_q = 0; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0) begin m_tc = 1; if (!sat) m_q = MAXV; end
          else m_q = m_q - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("q", 32'(q), 32'(m_q));
      chk("tc", 32'(tc), 32'(m_tc));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("q1", 32'(q1), (n == 0) ? 32'd0 : 32'((n - 1) % 16));
      chk("tick1", 32'(tick1), (n == 0) ? 32'd0 : 32'd1);
      chk("tc1", 32'(tc1), (n >= 2 && ((n - 1) % 16) == 0) ? 32'd1 : 32'd0);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b0; sat = 1'b0; load = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    @(negedge clk);                                   // edge 1
    chk("div1_first_tick", 32'(tick1), 32'd1);
    chk("div1_q_e1", 32'(q1), 32'd0);
    @(negedge clk);                                   // edge 2
    chk("div1_q_e2", 32'(q1), 32'd1);
    chk("tick_e2", 32'(tick), 32'd0);
    repeat (2) @(negedge clk);                        // edge 4
    chk("first_tick", 32'(tick), 32'd1);
    chk("q_before_step", 32'(q), 32'd0);
    @(negedge clk);                                   // edge 5
    chk("q_e5", 32'(q), 32'd1);
    repeat (4) @(negedge clk);                        // edge 9
    chk("q_e9", 32'(q), 32'd2);
    repeat (28) @(negedge clk);                       // edge 37
    chk("q_reach_max", 32'(q), 32'd9);
    repeat (4) @(negedge clk);                        // edge 41
    chk("wrap_q", 32'(q), 32'd0);
    chk("wrap_tc", 32'(tc), 32'd1);
    sat = 1'b1;
    @(negedge clk);                                   // edge 42
    chk("tc_one_cycle", 32'(tc), 32'd0);
    repeat (39) @(negedge clk);                       // edge 81
    chk("sat_q", 32'(q), 32'd9);
    chk("sat_tc", 32'(tc), 32'd1);
    @(negedge clk);                                   // edge 82
    chk("sat_tc_low", 32'(tc), 32'd0);
    repeat (3) @(negedge clk);                        // edge 85
    chk("sat_q2", 32'(q), 32'd9);
    chk("sat_tc2", 32'(tc), 32'd1);
    load = 1'b1; load_val = 4'd7; up_dn = 1'b0; sat = 1'b0;
    @(negedge clk);                                   // edge 86
    load = 1'b0;
    chk("load_q", 32'(q), 32'd7);
    chk("load_tc", 32'(tc), 32'd0);
    repeat (3) @(negedge clk);                        // edge 89
    chk("down_q", 32'(q), 32'd6);
    repeat (24) @(negedge clk);                       // edge 113
    chk("down_zero", 32'(q), 32'd0);
    repeat (4) @(negedge clk);                        // edge 117
    chk("down_wrap_q", 32'(q), 32'd9);
    chk("down_wrap_tc", 32'(tc), 32'd1);
    load = 1'b1; load_val = 4'd14;
    @(negedge clk);                                   // edge 118
    chk("clamp_q", 32'(q), 32'd9);
    load = 1'b0;
    repeat (2) @(negedge clk);                        // edge 120, tick high
    chk("coinc_tick", 32'(tick), 32'd1);
    load = 1'b1; load_val = 4'd3;
    @(negedge clk);                                   // edge 121
    load = 1'b0;
    chk("coinc_q", 32'(q), 32'd3);
    chk("coinc_tc", 32'(tc), 32'd0);
    en = 1'b0;
    repeat (8) @(negedge clk);                        // edge 129
    chk("en_frozen", 32'(q), 32'd3);
    en = 1'b1;
    repeat (3) @(negedge clk);                        // edge 132
    chk("reen_tick", 32'(tick), 32'd1);
    chk("reen_hold", 32'(q), 32'd3);
    @(negedge clk);                                   // edge 133
    chk("reen_step", 32'(q), 32'd2);
    up_dn = 1'b1;
    repeat (13) @(negedge clk);                       // edge 146
    chk("pre_rst_q", 32'(q), 32'd5);
    rst = 1'b0;
    @(negedge clk);                                   // reset edge
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_q1", 32'(q1), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_tick", 32'(tick), 32'd0);
    @(negedge clk);
    chk("post_rst_tick", 32'(tick), 32'd1);
    @(negedge clk);
    chk("post_rst_q", 32'(q), 32'd1);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_updown_counter.md
Name: tick_updown_counter

Overview:
Parametrised successor to the team's divided-clock up counter. A free-running prescaler produces a one-cycle tick every DIV system clocks. A WIDTH-bit counter steps up or down on each enabled tick, within a programmable modulus, in either wrap or saturate mode. Supports synchronous parallel load and a terminal-count pulse for cascading. Sits between the board clock and display or LED logic.

Parameters:
WIDTH, 4, counter width in bits (1..32)
DIV, 100_000_000, system clocks per tick (>=1); 100 MHz board clock gives 1 Hz
MAX_VAL, 2**WIDTH-1, highest count value (1..2**WIDTH-1); sets modulus MAX_VAL+1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
en  input  1  count enable; qualifies tick only
up_dn  input  1  1 = count up, 0 = count down; sampled on the tick edge
sat  input  1  1 = saturate at bounds, 0 = wrap
load  input  1  synchronous load strobe; not tick-gated
load_val  input  WIDTH  value loaded when load=1
q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
tick  output  1  prescaler tick (registered)

Behaviour:
- Reset (rst=0 at an edge): prescaler=0, tick=0, q=0, tc=0. Reset is fully synchronous and applies mid-count or mid-load.
- Prescaler: ceil(log2(DIV)) bits, free-running and independent of en, load, up_dn and sat. Counts 0..DIV-1. At DIV-1 it returns to 0 and sets tick=1 on that edge; tick=0 on all other edges. tick is high for exactly 1 of every DIV cycles.
- Prescaler timing: the first tick is high in the DIV-th cycle after rst is released. DIV=1 gives tick=1 every cycle after the first post-reset edge.
- Priority at each edge: rst > load > (tick & en) count step > hold.
- Load: q <= min(load_val, MAX_VAL); tc <= 0. Load wins over a coincident tick, and that tick's step is lost. The prescaler is unaffected by load.
- Count step (tick=1 & en=1 & load=0), up with q<MAX_VAL: q <= q+1; tc <= 0.
- Count step, up with q==MAX_VAL: q <= 0 if sat=0, or q holds MAX_VAL if sat=1; tc <= 1 in both cases.
- Count step, down with q>0: q <= q-1; tc <= 0.
- Count step, down with q==0: q <= MAX_VAL if sat=0, or q holds 0 if sat=1; tc <= 1 in both cases.
- tc timing: tc is registered with q, so it is high for exactly the one cycle following the boundary step. It is 0 on every other edge, including hold and load edges. Repeated saturated ticks give one tc pulse per tick.
- Latency: a step lands one edge after the cycle in which tick is high, i.e. q changes on edge DIV+1 after reset release.
- Other inputs: en=0 freezes q but not the prescaler; ticks during en=0 are dropped, not queued. up_dn and sat changes between ticks have no effect until the next tick edge.
- Arithmetic: modulo MAX_VAL+1 with no overflow past MAX_VAL. If MAX_VAL=2**WIDTH-1, natural wrap is acceptable.

Test Plan (WIDTH=4, DIV=4, MAX_VAL=9 unless noted):
- rst=0 for 3 cycles, then rst=1, en=1, up_dn=1, sat=0 -> tick high on cycles 4, 8, 12…; q=1 after edge 5, q=2 after edge 9; tc=0.
- Count up from q=9 -> next step gives q=0 and tc=1 for one cycle. With sat=1 -> q stays 9 and tc=1 on each tick.
- load=1, load_val=7, up_dn=0 -> q=7 the next edge; subsequent ticks give 6, 5, …, 0. At q=0 with sat=0, the next tick gives q=9 and tc=1.
- load_val=14 -> q=9 (clamped). load asserted on the same edge as tick -> q=load value, no step, tc=0.
- en toggled 0 across two ticks -> q frozen, prescaler keeps counting; after re-enable, the next step lands at the following tick (no burst).
- rst=0 mid-count (q=5, prescaler=2) for 1 cycle -> q=0, tc=0, tick=0, prescaler restarts; next tick high 4 cycles after release. DIV=1 -> q increments every cycle after reset.
